// File: rtl/acc_periph_write_pkg.sv
// rtl/acc_periph_write_pkg.sv - select codes, FSM encoding and decode helpers for the peripheral write port
package acc_periph_write_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_NONE      = 3'd0;
    localparam logic [SEL_W-1:0] SEL_TC_PRESET = 3'd1;
    localparam logic [SEL_W-1:0] SEL_TC_CTRL   = 3'd2;
    localparam logic [SEL_W-1:0] SEL_UART_TX   = 3'd3;
    localparam logic [SEL_W-1:0] SEL_SPI_CTRL  = 3'd4;
    localparam logic [SEL_W-1:0] SEL_SPI_BUF   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STROBE = 2'd2
    } state_e;

    typedef struct packed {
        logic spi_buf;
        logic spi_ctrl;
        logic uart_tx;
        logic tc_ctrl;
        logic tc_preset;
    } strobe_t;

    // A code is legal only if its peripheral is built into this variant.
    function automatic logic sel_legal(input logic [SEL_W-1:0] sel,
                                       input logic has_tc,
                                       input logic has_uart,
                                       input logic has_spi);
        case (sel)
            SEL_TC_PRESET, SEL_TC_CTRL: return has_tc;
            SEL_UART_TX:                return has_uart;
            SEL_SPI_CTRL, SEL_SPI_BUF:  return has_spi;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic target_ready(input logic [SEL_W-1:0] sel,
                                          input logic uart_rdy,
                                          input logic spi_rdy);
        case (sel)
            SEL_TC_PRESET, SEL_TC_CTRL: return 1'b1;
            SEL_UART_TX:                return uart_rdy;
            SEL_SPI_CTRL, SEL_SPI_BUF:  return spi_rdy;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic strobe_t sel_strobe(input logic [SEL_W-1:0] sel);
        strobe_t s;
        s = '0;
        case (sel)
            SEL_TC_PRESET: s.tc_preset = 1'b1;
            SEL_TC_CTRL:   s.tc_ctrl   = 1'b1;
            SEL_UART_TX:   s.uart_tx   = 1'b1;
            SEL_SPI_CTRL:  s.spi_ctrl  = 1'b1;
            SEL_SPI_BUF:   s.spi_buf   = 1'b1;
            default:       s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/acc_periph_write.sv
// rtl/acc_periph_write.sv - accumulator-to-peripheral write port with ready wait, timeout and sticky error
module acc_periph_write
    import acc_periph_write_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 8,
    parameter bit HAS_TC       = 1'b1,
    parameter bit HAS_UART     = 1'b1,
    parameter bit HAS_SPI      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrReq,
    input  logic [SEL_W-1:0] accWrSel,
    input  logic [7:0]       accIn,
    input  logic             uartTxReady,
    input  logic             spiBufReady,
    input  logic             errClr,
    output logic [7:0]       periphWrData,
    output logic             tcPresetWr,
    output logic             tcCtrlWr,
    output logic             uartTxWr,
    output logic             spiCtrlWr,
    output logic             spiBufWr,
    output logic             busy,
    output logic             wrErr
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(WAIT_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [7:0]       wdata_q, wdata_d;
    strobe_t          strobe_q, strobe_d;
    logic             err_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= SEL_NONE;
            data_q   <= 8'h00;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            wdata_q  <= 8'h00;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wrReq && (accWrSel != SEL_NONE)) begin
                    if (!sel_legal(accWrSel, HAS_TC, HAS_UART, HAS_SPI)) begin
                        err_set = 1'b1;
                    end else begin
                        sel_d   = accWrSel;
                        data_d  = accIn;
                        cnt_d   = '0;
                        state_d = target_ready(accWrSel, uartTxReady, spiBufReady)
                                  ? ST_STROBE : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Ready is checked before the timeout so a late ready still commits.
                if (target_ready(sel_q, uartTxReady, spiBufReady)) begin
                    state_d = ST_STROBE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STROBE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered off the next state so each strobe lines up with STROBE.
    always_comb begin
        err_d    = err_set | (err_q & ~errClr);
        busy_d   = (state_d != ST_IDLE);
        strobe_d = (state_d == ST_STROBE) ? sel_strobe(sel_d) : '0;
        wdata_d  = (state_d == ST_STROBE) ? data_d : wdata_q;
    end

    assign periphWrData = wdata_q;
    assign tcPresetWr   = strobe_q.tc_preset;
    assign tcCtrlWr     = strobe_q.tc_ctrl;
    assign uartTxWr     = strobe_q.uart_tx;
    assign spiCtrlWr    = strobe_q.spi_ctrl;
    assign spiBufWr     = strobe_q.spi_buf;
    assign busy         = busy_q;
    assign wrErr        = err_q;

endmodule

// File: tb/tb_acc_periph_write.sv
// tb/tb_acc_periph_write.sv - randomized self-checking bench for acc_periph_write
module tb_acc_periph_write;

    localparam int WT    = 16;
    localparam int NEVER = 1000;
    localparam int WIN   = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       wrReq;
    logic [2:0] accWrSel;
    logic [7:0] accIn;
    logic       uartTxReady;
    logic       spiBufReady;
    logic       errClr;
    logic [7:0] periphWrData;
    logic       tcPresetWr, tcCtrlWr, uartTxWr, spiCtrlWr, spiBufWr;
    logic       busy;
    logic       wrErr;

    always #5 clk = ~clk;

    acc_periph_write #(.WAIT_TIMEOUT(WT), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .wrReq        (wrReq),
        .accWrSel     (accWrSel),
        .accIn        (accIn),
        .uartTxReady  (uartTxReady),
        .spiBufReady  (spiBufReady),
        .errClr       (errClr),
        .periphWrData (periphWrData),
        .tcPresetWr   (tcPresetWr),
        .tcCtrlWr     (tcCtrlWr),
        .uartTxWr     (uartTxWr),
        .spiCtrlWr    (spiCtrlWr),
        .spiBufWr     (spiBufWr),
        .busy         (busy),
        .wrErr        (wrErr)
    );

    int total = 0;
    int bad   = 0;

    bit       err_m  = 1'b0;
    bit [7:0] last_m = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {spiBufWr, spiCtrlWr, uartTxWr, tcCtrlWr, tcPresetWr};
    endfunction

    // The addressed target becomes ready from cycle d on; the other ready line is noise.
    task automatic drive_ready(input int sel, input int d, input int c);
        bit rdy;
        rdy = (c >= d);
        uartTxReady = $urandom_range(0, 1);
        spiBufReady = $urandom_range(0, 1);
        if (sel == 3) uartTxReady = rdy;
        if (sel == 4 || sel == 5) spiBufReady = rdy;
    endtask

    // Cycle 0 presents the request; cycle c is the c-th cycle after the accepting edge.
    task automatic txn(input int sel, input logic [7:0] data, input int d,
                       input bit hold, input bit clr0);
        int exp_cyc, exp_busy, eff_d;
        int n_str, first, n_busy, last_busy, multi;
        logic [4:0] exp_vec, vec_seen, v;
        logic [7:0] data_seen;

        if (clr0) err_m = 1'b0;
        exp_cyc  = 0;
        exp_busy = 0;
        if (sel >= 1 && sel <= 5) begin
            eff_d = (sel <= 2) ? 0 : d;
            if (eff_d <= WT) begin
                exp_cyc  = eff_d + 1;
                exp_busy = eff_d + 1;
            end else begin
                exp_busy = WT;
                err_m    = 1'b1;
            end
        end else if (sel != 0) begin
            err_m = 1'b1;
        end
        exp_vec = (exp_cyc != 0) ? (5'b00001 << (sel - 1)) : 5'b00000;
        if (exp_cyc != 0) last_m = data;

        n_str = 0; first = 0; n_busy = 0; last_busy = 0; multi = 0;
        vec_seen = 5'b0; data_seen = 8'h00;
        wrReq    = 1'b1;
        accWrSel = 3'(sel);
        accIn    = data;
        errClr   = clr0;
        drive_ready(sel, d, 0);
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk);
            v = strobes();
            if (v != 5'b0) begin
                n_str++;
                if (first == 0) begin
                    first     = c;
                    vec_seen  = v;
                    data_seen = periphWrData;
                end
            end
            if ($countones(v) > 1) multi++;
            if (busy) begin
                n_busy++;
                last_busy = c;
            end
            wrReq  = hold && (c <= exp_busy);
            errClr = 1'b0;
            drive_ready(sel, d, c);
        end
        check($sformatf("strobe_count sel=%0d d=%0d", sel, d), n_str, (exp_cyc != 0) ? 1 : 0);
        check($sformatf("strobe_cycle sel=%0d d=%0d", sel, d), first, exp_cyc);
        check($sformatf("strobe_vec sel=%0d", sel), vec_seen, exp_vec);
        if (exp_cyc != 0) check($sformatf("strobe_data sel=%0d", sel), data_seen, data);
        check($sformatf("busy_len sel=%0d d=%0d", sel, d), n_busy, exp_busy);
        check($sformatf("busy_last sel=%0d d=%0d", sel, d), last_busy, exp_busy);
        check("strobe_exclusive", multi, 0);
        check($sformatf("wrErr sel=%0d d=%0d", sel, d), wrErr, err_m);
        check("data_hold", periphWrData, last_m);
    endtask

    task automatic clear_err();
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
        err_m  = 1'b0;
        check("errClr", wrErr, 1'b0);
    endtask

    initial begin
        int n_tc, n_uart;
        logic [7:0] d_tc [2];

        reset = 1'b0; wrReq = 1'b0; accWrSel = 3'd0; accIn = 8'h00;
        uartTxReady = 1'b0; spiBufReady = 1'b0; errClr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_strobes", strobes(), 5'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", wrErr, 1'b0);
        check("rst_data", periphWrData, 8'h00);
        reset = 1'b1;
        @(negedge clk);

        txn(1, 8'hA5, 0, 1'b0, 1'b0);
        txn(3, 8'h3C, 5, 1'b1, 1'b0);
        txn(5, 8'h5A, NEVER, 1'b0, 1'b0);
        check("timeout_err", wrErr, 1'b1);
        clear_err();
        txn(7, 8'h77, 0, 1'b0, 1'b0);
        clear_err();
        txn(4, 8'hC4, WT, 1'b0, 1'b0);
        txn(3, 8'hD3, WT + 1, 1'b0, 1'b0);
        txn(6, 8'h66, 0, 1'b0, 1'b1);

        // Back-to-back: wrReq held high, data changes after the first accept.
        n_tc = 0;
        wrReq = 1'b1; accWrSel = 3'd2; accIn = 8'h11;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (tcCtrlWr) begin
                if (n_tc < 2) d_tc[n_tc] = periphWrData;
                n_tc++;
                check($sformatf("b2b_cycle %0d", n_tc), c, (n_tc == 1) ? 1 : 3);
            end
            if (c == 2) accIn = 8'h22;
            if (c == 3) wrReq = 1'b0;
        end
        check("b2b_count", n_tc, 2);
        check("b2b_data0", d_tc[0], 8'h11);
        check("b2b_data1", d_tc[1], 8'h22);
        last_m = 8'h22;

        // Asynchronous reset while waiting on the UART.
        wrReq = 1'b1; accWrSel = 3'd3; accIn = 8'h99; uartTxReady = 1'b0;
        @(negedge clk);
        wrReq = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_strobes", strobes(), 5'b0);
        check("arst_err", wrErr, 1'b0);
        check("arst_data", periphWrData, 8'h00);
        @(negedge clk);
        reset = 1'b1; uartTxReady = 1'b1;
        err_m = 1'b0; last_m = 8'h00;
        n_uart = 0;
        repeat (10) begin
            @(negedge clk);
            if (uartTxWr) n_uart++;
        end
        check("arst_no_uart", n_uart, 0);
        check("arst_busy_after", busy, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int sel, d;
            sel = $urandom_range(0, 7);
            d   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, WT + 3);
            txn(sel, 8'($urandom), d, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) == 0) clear_err();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
